// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline constants (ALU/memory opcodes, datapath width defaults)
package id_ex_stage_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RADDR_W = 3;
  typedef enum logic [4:0] {
    OP_ADDI = 5'b01000,
    OP_ST   = 5'b10000,
    OP_LD   = 5'b10001,
    OP_STU  = 5'b10011,
    OP_ADD  = 5'b11011
  } op_e;
  typedef enum logic [1:0] {SUB_ADD, SUB_SUB, SUB_XOR, SUB_ANDN} sub_op_e;
endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// fwd_sel: producer match, EX/MEM-over-MEM/WB priority and operand mux for one source register.
// FWD_EN selects whether the forwarded value reaches the ALU or only the stall refresh path.
module fwd_sel import id_ex_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               en,
  input  logic [RADDR_W-1:0] src,
  input  logic [DATA_W-1:0]  stored,
  input  logic               exm_valid,
  input  logic               exm_reg_we,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]  exm_result,
  input  logic               mwb_valid,
  input  logic               mwb_reg_we,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [DATA_W-1:0]  mwb_result,
  output logic               exm_hit,
  output logic               mwb_hit,
  output logic [DATA_W-1:0]  fwd,
  output logic [DATA_W-1:0]  val
);
  assign exm_hit = en & exm_valid & exm_reg_we & (exm_rd == src);
  assign mwb_hit = en & mwb_valid & mwb_reg_we & (mwb_rd == src);
  assign fwd = exm_hit ? exm_result : mwb_hit ? mwb_result : stored;
`ifdef FWD_EN
  assign val = fwd;
`else
  assign val = stored;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use hazard detection.
// Define FWD_EN for full forwarding; otherwise operands come from stored data and any pending writer interlocks.
module id_ex_stage import id_ex_stage_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               id_valid,
  input  logic [4:0]         id_op,
  input  logic [1:0]         id_sub_op,
  input  logic               id_nA,
  input  logic               id_nB,
  input  logic               id_cin,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               id_use_imm,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [DATA_W-1:0]  id_pc_inc,
  input  logic               id_reg_we,
  input  logic               id_is_load,
  input  logic               id_mem_we,
  input  logic               exm_valid,
  input  logic               exm_reg_we,
  input  logic               exm_is_load,
  input  logic [RADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]  exm_result,
  input  logic               mwb_valid,
  input  logic               mwb_reg_we,
  input  logic [RADDR_W-1:0] mwb_rd,
  input  logic [DATA_W-1:0]  mwb_result,
  output logic               ex_valid,
  output logic [4:0]         ex_op,
  output logic [1:0]         ex_sub_op,
  output logic               ex_nA,
  output logic               ex_nB,
  output logic               ex_cin,
  output logic [DATA_W-1:0]  ex_A,
  output logic [DATA_W-1:0]  ex_B,
  output logic [DATA_W-1:0]  ex_st_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_we,
  output logic               ex_is_load,
  output logic               ex_mem_we,
  output logic [DATA_W-1:0]  ex_pc_inc,
  output logic               ex_hazard
);
  logic [RADDR_W-1:0] rs, rt;
  logic rs_used, rt_used, use_imm;
  logic [DATA_W-1:0] rs_data, rt_data, imm;
  logic [DATA_W-1:0] rs_fwd, rt_fwd, rs_val, rt_val;
  logic rs_exm_hit, rs_mwb_hit, rt_exm_hit, rt_mwb_hit;

  fwd_sel #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rs (
    .en(ex_valid & rs_used), .src(rs), .stored(rs_data),
    .exm_valid(exm_valid), .exm_reg_we(exm_reg_we), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_valid(mwb_valid), .mwb_reg_we(mwb_reg_we), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .exm_hit(rs_exm_hit), .mwb_hit(rs_mwb_hit), .fwd(rs_fwd), .val(rs_val)
  );

  fwd_sel #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rt (
    .en(ex_valid & rt_used), .src(rt), .stored(rt_data),
    .exm_valid(exm_valid), .exm_reg_we(exm_reg_we), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_valid(mwb_valid), .mwb_reg_we(mwb_reg_we), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .exm_hit(rt_exm_hit), .mwb_hit(rt_mwb_hit), .fwd(rt_fwd), .val(rt_val)
  );

  // Stalled operands keep absorbing producer results, so a writer that retires mid-stall is not lost.
  always_ff @(posedge clk)
    if (rst || flush) begin
      ex_valid <= 1'b0;
      ex_op <= '0;
      ex_sub_op <= '0;
      ex_nA <= 1'b0;
      ex_nB <= 1'b0;
      ex_cin <= 1'b0;
      rs <= '0;
      rt <= '0;
      ex_rd <= '0;
      rs_used <= 1'b0;
      rt_used <= 1'b0;
      use_imm <= 1'b0;
      rs_data <= '0;
      rt_data <= '0;
      imm <= '0;
      ex_pc_inc <= '0;
      ex_reg_we <= 1'b0;
      ex_is_load <= 1'b0;
      ex_mem_we <= 1'b0;
    end else if (stall) begin
      rs_data <= rs_fwd;
      rt_data <= rt_fwd;
    end else begin
      ex_valid <= id_valid;
      ex_op <= id_op;
      ex_sub_op <= id_sub_op;
      ex_nA <= id_nA;
      ex_nB <= id_nB;
      ex_cin <= id_cin;
      rs <= id_rs;
      rt <= id_rt;
      ex_rd <= id_rd;
      rs_used <= id_rs_used;
      rt_used <= id_rt_used;
      use_imm <= id_use_imm;
      rs_data <= id_rs_data;
      rt_data <= id_rt_data;
      imm <= id_imm;
      ex_pc_inc <= id_pc_inc;
      ex_reg_we <= id_reg_we;
      ex_is_load <= id_is_load;
      ex_mem_we <= id_mem_we;
    end

  assign ex_A = rs_val;
  assign ex_B = use_imm ? imm : rt_val;
  assign ex_st_data = rt_val;

`ifdef FWD_EN
  assign ex_hazard = ex_valid & exm_is_load & (rs_exm_hit | rt_exm_hit);
`else
  logic unused_is_load;
  assign unused_is_load = exm_is_load;
  assign ex_hazard = rs_exm_hit | rt_exm_hit | rs_mwb_hit | rt_mwb_hit;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a behavioural model (honours FWD_EN).
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic id_valid, id_nA, id_nB, id_cin, id_rs_used, id_rt_used, id_use_imm, id_reg_we, id_is_load, id_mem_we;
  logic [4:0] id_op;
  logic [1:0] id_sub_op;
  logic [2:0] id_rs, id_rt, id_rd, exm_rd, mwb_rd;
  logic [15:0] id_rs_data, id_rt_data, id_imm, id_pc_inc, exm_result, mwb_result;
  logic exm_valid, exm_reg_we, exm_is_load, mwb_valid, mwb_reg_we;
  logic ex_valid, ex_nA, ex_nB, ex_cin, ex_reg_we, ex_is_load, ex_mem_we, ex_hazard;
  logic [4:0] ex_op;
  logic [1:0] ex_sub_op;
  logic [2:0] ex_rd;
  logic [15:0] ex_A, ex_B, ex_st_data, ex_pc_inc;
  int checks = 0, failures = 0;

  logic m_valid, m_nA, m_nB, m_cin, m_rs_used, m_rt_used, m_use_imm, m_reg_we, m_is_load, m_mem_we;
  logic [4:0] m_op;
  logic [1:0] m_sub;
  logic [2:0] m_rs, m_rt, m_rd;
  logic [15:0] m_rs_data, m_rt_data, m_imm, m_pc;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_op(id_op), .id_sub_op(id_sub_op), .id_nA(id_nA), .id_nB(id_nB), .id_cin(id_cin),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_use_imm(id_use_imm), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_pc_inc(id_pc_inc), .id_reg_we(id_reg_we), .id_is_load(id_is_load), .id_mem_we(id_mem_we),
    .exm_valid(exm_valid), .exm_reg_we(exm_reg_we), .exm_is_load(exm_is_load), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_valid(mwb_valid), .mwb_reg_we(mwb_reg_we), .mwb_rd(mwb_rd),
    .mwb_result(mwb_result), .ex_valid(ex_valid), .ex_op(ex_op), .ex_sub_op(ex_sub_op), .ex_nA(ex_nA),
    .ex_nB(ex_nB), .ex_cin(ex_cin), .ex_A(ex_A), .ex_B(ex_B), .ex_st_data(ex_st_data), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load), .ex_mem_we(ex_mem_we), .ex_pc_inc(ex_pc_inc),
    .ex_hazard(ex_hazard)
  );

  always #5 clk = ~clk;

  function automatic logic exm_writes(input logic [2:0] r, input logic used);
    return m_valid && used && exm_valid && exm_reg_we && exm_rd == r;
  endfunction

  function automatic logic mwb_writes(input logic [2:0] r, input logic used);
    return m_valid && used && mwb_valid && mwb_reg_we && mwb_rd == r;
  endfunction

  function automatic logic [15:0] newest(input logic [2:0] r, input logic used, input logic [15:0] stored);
    if (exm_writes(r, used)) return exm_result;
    if (mwb_writes(r, used)) return mwb_result;
    return stored;
  endfunction

  function automatic logic [81:0] exp_vec();
    logic [15:0] a, b;
    logic hz;
`ifdef FWD_EN
    a = newest(m_rs, m_rs_used, m_rs_data);
    b = newest(m_rt, m_rt_used, m_rt_data);
    hz = exm_is_load && (exm_writes(m_rs, m_rs_used) || exm_writes(m_rt, m_rt_used));
`else
    a = m_rs_data;
    b = m_rt_data;
    hz = exm_writes(m_rs, m_rs_used) || exm_writes(m_rt, m_rt_used) ||
         mwb_writes(m_rs, m_rs_used) || mwb_writes(m_rt, m_rt_used);
`endif
    return {m_valid, m_op, m_sub, m_nA, m_nB, m_cin, a, m_use_imm ? m_imm : b, b,
            m_rd, m_reg_we, m_is_load, m_mem_we, m_pc, hz};
  endfunction

  function automatic logic [81:0] act_vec();
    return {ex_valid, ex_op, ex_sub_op, ex_nA, ex_nB, ex_cin, ex_A, ex_B, ex_st_data,
            ex_rd, ex_reg_we, ex_is_load, ex_mem_we, ex_pc_inc, ex_hazard};
  endfunction

  task automatic tick();
    logic [15:0] a, b;
    @(posedge clk);
    a = newest(m_rs, m_rs_used, m_rs_data);
    b = newest(m_rt, m_rt_used, m_rt_data);
    if (rst || flush) begin
      {m_valid, m_op, m_sub, m_nA, m_nB, m_cin, m_rs, m_rt, m_rd, m_rs_used, m_rt_used, m_use_imm} = '0;
      {m_rs_data, m_rt_data, m_imm, m_pc, m_reg_we, m_is_load, m_mem_we} = '0;
    end else if (stall) begin
      m_rs_data = a;
      m_rt_data = b;
    end else begin
      {m_valid, m_op, m_sub, m_nA, m_nB, m_cin} = {id_valid, id_op, id_sub_op, id_nA, id_nB, id_cin};
      {m_rs, m_rt, m_rd, m_rs_used, m_rt_used, m_use_imm} = {id_rs, id_rt, id_rd, id_rs_used, id_rt_used, id_use_imm};
      {m_rs_data, m_rt_data, m_imm, m_pc} = {id_rs_data, id_rt_data, id_imm, id_pc_inc};
      {m_reg_we, m_is_load, m_mem_we} = {id_reg_we, id_is_load, id_mem_we};
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] op, input logic [2:0] rs, rt, rd,
                        input logic rsu, rtu, imm_sel, input logic [15:0] rsd, rtd, imm);
    {id_valid, id_op, id_rs, id_rt, id_rd, id_rs_used, id_rt_used, id_use_imm} = {v, op, rs, rt, rd, rsu, rtu, imm_sel};
    {id_rs_data, id_rt_data, id_imm} = {rsd, rtd, imm};
    id_sub_op = 2'($urandom);
    {id_nA, id_nB, id_cin} = 3'($urandom);
    id_pc_inc = 16'($urandom);
    id_reg_we = 1'b1;
    id_is_load = 1'b0;
    id_mem_we = 1'b0;
  endtask

  task automatic set_prod(input logic ev, ewe, eld, input logic [2:0] erd, input logic [15:0] eres,
                          input logic mv, mwe, input logic [2:0] mrd, input logic [15:0] mres);
    {exm_valid, exm_reg_we, exm_is_load, exm_rd, exm_result} = {ev, ewe, eld, erd, eres};
    {mwb_valid, mwb_reg_we, mwb_rd, mwb_result} = {mv, mwe, mrd, mres};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1, OP_ADD, 1, 2, 3, 1, 1, 0, 16'h1111, 16'h2222, 16'h3333);
    set_prod(1, 1, 1, 1, 16'h4444, 1, 1, 2, 16'h5555);
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (act_vec() !== 82'h0) begin
      failures++;
      $display("FAIL reset outputs got=%h want=0", act_vec());
    end
  endtask

  task automatic test_addi();
    set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, OP_ADDI, 2, 0, 1, 1, 0, 1, 16'h0010, 16'h0000, 16'h0005);
    tick();
    id_valid = 1'b0;
    #1;
    checks += 4;
    if (ex_valid !== 1'b1) begin failures++; $display("FAIL addi ex_valid got=%b want=1", ex_valid); end
    if (ex_A !== 16'h0010) begin failures++; $display("FAIL addi ex_A got=%h want=0010", ex_A); end
    if (ex_B !== 16'h0005) begin failures++; $display("FAIL addi ex_B got=%h want=0005", ex_B); end
    if (ex_hazard !== 1'b0) begin failures++; $display("FAIL addi ex_hazard got=%b want=0", ex_hazard); end
  endtask

  task automatic test_fwd_priority();
    logic [15:0] want_a;
    logic want_hz;
    set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, OP_ADD, 3, 5, 6, 1, 1, 0, 16'h1111, 16'h2222, 16'h0);
    tick();
    set_prod(1, 1, 0, 3, 16'h1234, 1, 1, 3, 16'h5678);
    #1;
`ifdef FWD_EN
    want_a = 16'h1234; want_hz = 1'b0;
`else
    want_a = 16'h1111; want_hz = 1'b1;
`endif
    checks += 3;
    if (ex_A !== want_a) begin failures++; $display("FAIL prio ex_A got=%h want=%h", ex_A, want_a); end
    if (ex_hazard !== want_hz) begin failures++; $display("FAIL prio hazard got=%b want=%b", ex_hazard, want_hz); end
    if (act_vec() !== exp_vec()) begin failures++; $display("FAIL prio vec got=%h want=%h", act_vec(), exp_vec()); end
    set_prod(0, 0, 0, 0, 0, 1, 1, 3, 16'h5678);
    #1;
`ifdef FWD_EN
    want_a = 16'h5678;
`endif
    checks++;
    if (ex_A !== want_a) begin failures++; $display("FAIL mwb_only ex_A got=%h want=%h", ex_A, want_a); end
  endtask

  task automatic test_load_use();
    bit done = 0;
    set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, OP_ADD, 7, 4, 2, 1, 1, 0, 16'h7777, 16'h4444, 16'h0);
    tick();
    id_valid = 1'b0;
    set_prod(1, 1, 1, 4, 16'hDEAD, 0, 0, 0, 0);
    #1;
    checks++;
    if (ex_hazard !== 1'b1) begin failures++; $display("FAIL load_use hazard got=%b want=1", ex_hazard); end
    stall = 1'b1;
    tick();
    for (int c = 1; c < 4 && !done; c++) begin
      if (c == 1) set_prod(0, 0, 0, 0, 0, 1, 1, 4, 16'hBEEF);
      else set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (act_vec() !== exp_vec()) begin failures++; $display("FAIL load_use vec c=%0d got=%h want=%h", c, act_vec(), exp_vec()); end
      if (!exp_vec()[0]) begin
        done = 1;
        checks += 2;
        if (ex_B !== 16'hBEEF) begin failures++; $display("FAIL load_use ex_B got=%h want=beef", ex_B); end
        if (ex_hazard !== 1'b0) begin failures++; $display("FAIL load_use release hazard got=%b want=0", ex_hazard); end
      end else tick();
    end
    stall = 1'b0;
    checks++;
    if (!done) begin failures++; $display("FAIL load_use timeout got=stalled want=released"); end
  endtask

  task automatic test_flush_stall();
    set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, OP_LD, 1, 2, 3, 1, 0, 1, 16'hAAAA, 16'hBBBB, 16'h0042);
    tick();
    checks++;
    if (ex_valid !== 1'b1) begin failures++; $display("FAIL flush pre ex_valid got=%b want=1", ex_valid); end
    stall = 1'b1;
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    checks++;
    if (act_vec() !== 82'h0) begin failures++; $display("FAIL flush_stall outputs got=%h want=0", act_vec()); end
  endtask

  task automatic test_no_forward();
    set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, OP_ADD, 2, 3, 5, 1, 0, 0, 16'hAAAA, 16'hBBBB, 16'h0);
    tick();
    set_prod(1, 0, 0, 2, 16'h1234, 1, 1, 3, 16'h5678);
    #1;
    checks += 3;
    if (ex_A !== 16'hAAAA) begin failures++; $display("FAIL nowe ex_A got=%h want=aaaa", ex_A); end
    if (ex_B !== 16'hBBBB) begin failures++; $display("FAIL unused_rt ex_B got=%h want=bbbb", ex_B); end
    if (ex_hazard !== 1'b0) begin failures++; $display("FAIL nofwd hazard got=%b want=0", ex_hazard); end
  endtask

  task automatic test_mwb_interlock();
    logic [15:0] want_a;
    logic want_hz;
    set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, OP_ADD, 1, 5, 6, 1, 1, 0, 16'h0101, 16'h0505, 16'h0);
    tick();
    set_prod(0, 0, 0, 0, 0, 1, 1, 1, 16'h4242);
    #1;
`ifdef FWD_EN
    want_a = 16'h4242; want_hz = 1'b0;
`else
    want_a = 16'h0101; want_hz = 1'b1;
`endif
    checks += 2;
    if (ex_A !== want_a) begin failures++; $display("FAIL mwb ex_A got=%h want=%h", ex_A, want_a); end
    if (ex_hazard !== want_hz) begin failures++; $display("FAIL mwb hazard got=%b want=%b", ex_hazard, want_hz); end
  endtask

  task automatic test_reset_mid_stall();
    set_prod(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_id(1, OP_ADD, 0, 4, 2, 0, 1, 0, 16'h0, 16'h4444, 16'h0);
    tick();
    set_prod(1, 1, 1, 4, 16'hDEAD, 0, 0, 0, 0);
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stall = 1'b0;
    checks++;
    if (act_vec() !== 82'h0) begin failures++; $display("FAIL rst_mid_stall outputs got=%h want=0", act_vec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
             3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      {id_reg_we, id_is_load, id_mem_we} = 3'($urandom);
      set_prod(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom),
               1'($urandom), 1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom));
      #1;
      checks++;
      if (act_vec() !== exp_vec()) begin failures++; $display("FAIL random i=%0d got=%h want=%h", i, act_vec(), exp_vec()); end
      stall = exp_vec()[0] || $urandom_range(0, 9) == 0;
      flush = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 49) == 0;
      tick();
    end
    {rst, stall, flush} = 3'b000;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_fwd_priority();
    test_load_use();
    test_flush_stall();
    test_no_forward();
    test_mwb_interlock();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
